uart_word_join: RTL

Receive-side counterpart of the transmit word path: accepts the byte stream produced by the UART receiver and reassembles it into full-width words for the core. Bytes are packed most-significant part first. Each completed word is held in a one-entry output register with a valid/ready handshake. An optional inter-byte timeout discards partial words so the assembler resynchronises after line glitches.

---
 rtl/uart_word_join_if.sv | 36 +++
 rtl/uart_word_join.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_word_join_if.sv
// -----------------------------------------------------------------------------
// uart_word_join_if
// Bundles the byte-in / word-out signals of uart_word_join.
//   master : the assembler side (consumes bytes, produces words and flags)
//   slave  : the environment side (UART receiver plus word consumer)
// Signals:
//   byte_in     [WORD_PART] received byte, qualified by byte_valid
//   byte_valid  one-cycle pulse per received byte
//   word_out    [WORD_SIZE] assembled word, stable while word_valid=1
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer accepts word_out when word_valid=1
//   overflow    sticky, a completed word was dropped
//   timeout_err one-cycle pulse, a partial word was discarded
// -----------------------------------------------------------------------------
interface uart_word_join_if #(
  parameter int WORD_SIZE = 32,
  parameter int WORD_PART = 8
);
  logic [WORD_PART-1:0] byte_in;
  logic                 byte_valid;
  logic [WORD_SIZE-1:0] word_out;
  logic                 word_valid;
  logic                 word_ready;
  logic                 overflow;
  logic                 timeout_err;

  modport master (
    input  byte_in, byte_valid, word_ready,
    output word_out, word_valid, overflow, timeout_err
  );

  modport slave (
    output byte_in, byte_valid, word_ready,
    input  word_out, word_valid, overflow, timeout_err
  );
endinterface

// File: rtl/uart_word_join.sv
// -----------------------------------------------------------------------------
// uart_word_join
// Reassembles a UART byte stream into WORD_SIZE-bit words, first byte into the
// most-significant part. Completed words sit in a one-entry output register
// with a valid/ready handshake; a completion that finds the register full and
// not being drained is dropped and sets the sticky overflow flag.
// Optional feature macro: UART_WORD_JOIN_TIMEOUT_EN
//   defined   : an inter-byte timer discards a stalled partial word and pulses
//               timeout_err
//   undefined : no timer, timeout_err tied low, partial words held forever
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    uart_word_join_if.master (byte input, word output, status flags)
// WORD_SIZE must be a multiple of WORD_PART with at least two parts.
// -----------------------------------------------------------------------------
module uart_word_join #(
  parameter int WORD_SIZE     = 32,
  parameter int WORD_PART     = 8,
  parameter int CLQ_FREQ      = 200_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  uart_word_join_if.master  bus
);

  localparam int PARTS = WORD_SIZE / WORD_PART;
  localparam int CNT_W = (PARTS > 1) ? $clog2(PARTS) : 1;

  // The byte counter is the state: zero means no partial word is held.
  typedef enum logic {ST_IDLE, ST_ASSEMBLE} state_e;

  state_e               state;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [WORD_SIZE-1:0] next_word;
  logic                 last_part;
  logic                 complete;
  logic                 out_free;
  logic                 expire;

  assign state     = (cnt_q == '0) ? ST_IDLE : ST_ASSEMBLE;
  assign last_part = (cnt_q == CNT_W'(PARTS - 1));
  assign next_word = {shift_q[WORD_SIZE-WORD_PART-1:0], bus.byte_in};
  assign complete  = bus.byte_valid && last_part;
  // The output slot can take a new word if empty or drained this very cycle.
  assign out_free  = !valid_q || bus.word_ready;

`ifdef UART_WORD_JOIN_TIMEOUT_EN
  localparam int LIMIT = TIMEOUT_BYTES * 10 * (CLQ_FREQ / BAUD_RATE);
  localparam int TMR_W = $clog2(LIMIT + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             terr_q, terr_d;

  // A byte in the expiry cycle takes priority over the timeout.
  assign expire = (state == ST_ASSEMBLE) && !bus.byte_valid &&
                  (tmr_q == TMR_W'(LIMIT - 1));

  always_comb begin
    tmr_d  = tmr_q;
    terr_d = 1'b0;
    if (bus.byte_valid) begin
      tmr_d = '0;
    end else if (expire) begin
      tmr_d  = '0;
      terr_d = 1'b1;
    end else if (state == ST_ASSEMBLE) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (valid_q && bus.word_ready) begin
      valid_d = 1'b0;
    end

    if (bus.byte_valid) begin
      shift_d = next_word;
      cnt_d   = last_part ? '0 : cnt_q + CNT_W'(1);
    end else if (expire) begin
      cnt_d   = '0;
      shift_d = '0;
    end

    if (complete) begin
      if (out_free) begin
        word_d  = next_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.overflow   = ovf_q;

endmodule
